serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx_if.sv | 11 +
 rtl/serial_frame_tx.sv | 110 +++++++++++
 tb/tb_serial_frame_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// rtl/serial_frame_tx_if.sv - word handshake into the serial frame transmitter
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - start/data(LSB first)/stop single-wire frame transmitter
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_frame_tx_if.slave        s_if,
  output logic                    tx,
  output logic                    busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_nxt;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  assign s_if.tx_ready = (state_q == S_IDLE);
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign shift_nxt     = shift_q >> 1;

  // tx_d is the line value for the cycle after this edge, so every
  // transition loads the first value of the bit it enters.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (s_if.tx_valid) begin
          shift_d = s_if.tx_data;
          cyc_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          shift_d = shift_nxt;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = shift_nxt[0];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - directed self-checking bench for serial_frame_tx
module tb_serial_frame_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  logic tx_a, busy_a, tx_b, busy_b;
  int   errors = 0;
  int   checks = 0;

  serial_frame_tx_if #(.DATA_W(DW)) ifa ();
  serial_frame_tx_if #(.DATA_W(DW)) ifb ();

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .s_if (ifa),
    .tx   (tx_a),
    .busy (busy_a)
  );

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .s_if (ifb),
    .tx   (tx_b),
    .busy (busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [DW-1:0] d);
    int n = 0;
    while (!ifa.tx_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_before_send", ifa.tx_ready, 1);
    ifa.tx_data  = d;
    ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_valid = 1'b0;
  endtask

  // Called on the first start-bit cycle; returns on the cycle after the frame.
  task automatic frame_a(input string tag, input logic [DW-1:0] d, input int chg_bit,
                         input logic [DW-1:0] chg_data, input logic chg_valid);
    logic exp_bit;
    for (int b = 0; b < DW + 2; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b == chg_bit && c == 0) begin
          ifa.tx_data  = chg_data;
          ifa.tx_valid = chg_valid;
        end
        if (b == 0)           exp_bit = 1'b0;
        else if (b == DW + 1) exp_bit = 1'b1;
        else                  exp_bit = d[b-1];
        check($sformatf("%s_tx_b%0d_c%0d", tag, b, c), tx_a, exp_bit);
        check($sformatf("%s_busy_b%0d", tag, b), busy_a, 1);
        check($sformatf("%s_ready_b%0d", tag, b), ifa.tx_ready, 0);
        tick();
      end
    end
    check({tag, "_end_busy"}, busy_a, 0);
    check({tag, "_end_tx"}, tx_a, 1);
    check({tag, "_end_ready"}, ifa.tx_ready, 1);
  endtask

  initial begin
    rst          = 1'b1;
    ifa.tx_valid = 1'b1;
    ifa.tx_data  = 8'hAA;
    ifb.tx_valid = 1'b1;
    ifb.tx_data  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_tx", tx_a, 1);
      check("rst_busy", busy_a, 0);
      check("rst_busy_b", busy_b, 0);
    end
    rst          = 1'b0;
    ifa.tx_valid = 1'b0;
    ifb.tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_tx", tx_a, 1);
      check("post_rst_busy", busy_a, 0);
      check("post_rst_ready", ifa.tx_ready, 1);
      check("post_rst_ready_b", ifb.tx_ready, 1);
    end

    send_a(8'hA5);
    frame_a("a5", 8'hA5, -1, 8'h00, 1'b0);

    send_a(8'h3C);
    frame_a("3c", 8'h3C, 3, 8'hFF, 1'b0);

    ifa.tx_data  = 8'h01;
    ifa.tx_valid = 1'b1;
    tick();
    frame_a("b2b1", 8'h01, 1, 8'h80, 1'b1);
    tick();
    frame_a("b2b2", 8'h80, 1, 8'h80, 1'b0);

    send_a(8'h55);
    repeat (4 * CPB) tick();
    check("mid_bit3_tx", tx_a, 0);
    check("mid_bit3_busy", busy_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", tx_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_ready", ifa.tx_ready, 1);
    tick();
    check("abort_tx2", tx_a, 1);
    check("abort_busy2", busy_a, 0);
    send_a(8'h0F);
    frame_a("0f", 8'h0F, -1, 8'h00, 1'b0);

    check("b_ready", ifb.tx_ready, 1);
    ifb.tx_data  = 8'h00;
    ifb.tx_valid = 1'b1;
    tick();
    ifb.tx_valid = 1'b0;
    for (int i = 0; i < DW + 2; i++) begin
      check($sformatf("cpb1_tx_%0d", i), tx_b, (i == DW + 1) ? 1 : 0);
      check($sformatf("cpb1_busy_%0d", i), busy_b, 1);
      tick();
    end
    check("cpb1_end_busy", busy_b, 0);
    check("cpb1_end_ready", ifb.tx_ready, 1);
    check("cpb1_end_tx", tx_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
